// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment entry board: segment table,
// blank pattern and the digit-count ceiling.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}, indexed by hex value 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus a stability counter for one push-button.
// rise is combinational and high on the edge where the debounced level goes 0->1.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic             expire;

    // The synchronised input has differed from level for the full window.
    assign expire = (sync_2 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise   = expire && sync_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (expire) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_digit_entry_scanner.sv
// Multi-digit hex entry: debounced per-digit buttons load the switch value,
// and a time-multiplexed scanner drives the shared active-low display.
module seg_digit_entry_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 250000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              bcd,
    input  logic [NUM_DIGITS-1:0]   button,
    input  logic                    clear,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              cathodes,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    dp,
    output logic [4*NUM_DIGITS-1:0] digits_value,
    output logic                    entry_valid
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [3:0]              bcd_s1;
    logic [3:0]              bcd_s2;
    logic [NUM_DIGITS-1:0]   rise;
    logic [NUM_DIGITS-1:0]   db_level_unused;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [REF_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   onehot;

    assign dp           = 1'b1;
    assign digits_value = digits_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_s1 <= '0;
            bcd_s2 <= '0;
        end else begin
            bcd_s1 <= bcd;
            bcd_s2 <= bcd_s1;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .btn   (button[i]),
            .level (db_level_unused[i]),
            .rise  (rise[i])
        );
    end

    // entry_valid is a one-cycle strobe with no ready: it fires on the edge a
    // digit loads and downstream logic must sample it during that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q    <= '0;
            entry_valid <= 1'b0;
        end else if (clear) begin
            digits_q    <= '0;
            entry_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (rise[i]) begin
                    digits_q[4*i +: 4] <= bcd_s2;
                end
            end
            entry_valid <= |rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_digit        = digits_q[4*scan_idx +: 4];
        onehot           = '0;
        onehot[scan_idx] = 1'b1;
    end

    // Anode and cathode come from the same scan_idx so they never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes   <= '1;
            cathodes <= SEG_BLANK;
        end else begin
            anodes   <= ~onehot | blank_mask;
            cathodes <= blank_mask[scan_idx] ? SEG_BLANK : seg_encode(cur_digit);
        end
    end

endmodule
